// File: rtl/decoder_scan.sv
// Binary-to-one-hot decoder with direct select or prescaled auto-scan.
// All outputs come straight from flops; reset is asynchronous.
module decoder_scan #(
  parameter int W          = 2,
  parameter int PRESC      = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              mode,
  input  logic [W-1:0]      binary_in,
  output logic [2**W-1:0]   one_hot_out,
  output logic [W-1:0]      sel_out,
  output logic              tick,
  output logic              wrap
);

  localparam int N  = 2**W;
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  localparam logic [PW-1:0] PC_TOP  = PW'(PRESC - 1);
  localparam logic [W-1:0]  IDX_TOP = W'(N - 1);
  localparam logic [N-1:0]  ONE     = N'(1);

  logic [PW-1:0] pc_q, pc_d;
  logic [W-1:0]  idx_q, idx_d;
  logic [N-1:0]  oh_q, oh_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic          step;

  always_comb begin
    step   = (pc_q == PC_TOP);
    pc_d   = pc_q;
    idx_d  = idx_q;
    oh_d   = '0;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    unique case (1'b1)
      !en: begin
      end
      en && !mode: begin
        idx_d = binary_in;
        pc_d  = '0;
        oh_d  = ONE << binary_in;
      end
      en && mode: begin
        pc_d   = step ? '0 : pc_q + 1'b1;
        idx_d  = step ? idx_q + 1'b1 : idx_q;
        tick_d = step;
        wrap_d = step && (idx_q == IDX_TOP);
        oh_d   = ONE << idx_d;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= '0;
      idx_q  <= '0;
      oh_q   <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      idx_q  <= idx_d;
      oh_q   <= oh_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  // Polarity flip sits after the flop, so reset yields all-inactive either way.
  assign one_hot_out = ACTIVE_LOW ? ~oh_q : oh_q;
  assign sel_out     = idx_q;
  assign tick        = tick_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan with an expected-value queue.
// Two instances: W=2/active-high and W=3/active-low.
module tb_decoder_scan;

  typedef struct {
    logic [3:0] oh;
    logic [1:0] sel;
    logic       tk;
    logic       wr;
    logic [7:0] oh2;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, mode;
  logic [1:0] bin;
  logic [3:0] oh;
  logic [1:0] sel;
  logic       tick, wrap;

  logic       en2, mode2;
  logic [2:0] bin2;
  logic [7:0] oh2;
  logic [2:0] sel2;
  logic       tick2, wrap2;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  decoder_scan #(.W(2), .PRESC(3), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .binary_in(bin), .one_hot_out(oh), .sel_out(sel),
    .tick(tick), .wrap(wrap)
  );

  decoder_scan #(.W(3), .PRESC(3), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .reset(reset), .en(en2), .mode(mode2),
    .binary_in(bin2), .one_hot_out(oh2), .sel_out(sel2),
    .tick(tick2), .wrap(wrap2)
  );

  function automatic exp_t mk(
    input logic [3:0] o, input logic [1:0] s,
    input logic t, input logic w, input logic [7:0] o2
  );
    exp_t x;
    x.oh = o; x.sel = s; x.tk = t; x.wr = w; x.oh2 = o2;
    return x;
  endfunction

  task automatic chk(input string tag);
    exp_t x;
    x = q.pop_front();
    n_vec++;
    assert (oh === x.oh) else begin
      n_bad++;
      $error("FAIL %s one_hot got %b want %b", tag, oh, x.oh);
    end
    assert (sel === x.sel) else begin
      n_bad++;
      $error("FAIL %s sel got %0d want %0d", tag, sel, x.sel);
    end
    assert (tick === x.tk) else begin
      n_bad++;
      $error("FAIL %s tick got %b want %b", tag, tick, x.tk);
    end
    assert (wrap === x.wr) else begin
      n_bad++;
      $error("FAIL %s wrap got %b want %b", tag, wrap, x.wr);
    end
    assert (oh2 === x.oh2) else begin
      n_bad++;
      $error("FAIL %s al_one_hot got %b want %b", tag, oh2, x.oh2);
    end
  endtask

  // Called at a falling edge; checks after the next rising edge.
  task automatic drive(
    input string tag,
    input logic e, input logic m, input logic [1:0] b,
    input logic e2, input logic [2:0] b2, input exp_t x
  );
    en = e; mode = m; bin = b;
    en2 = e2; mode2 = 1'b0; bin2 = b2;
    q.push_back(x);
    @(negedge clk);
    chk(tag);
  endtask

  task automatic async_rst(input string tag);
    reset = 1'b1;
    #1;
    q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0, 8'hFF));
    chk(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    en = 1'b0; mode = 1'b0; bin = '0;
    en2 = 1'b0; mode2 = 1'b0; bin2 = '0;
    #2;
    q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0, 8'hFF));
    chk("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int b = 0; b < 4; b++)
      drive("direct", 1, 0, 2'(b), 0, 3'd0,
            mk(4'b0001 << b, 2'(b), 0, 0, 8'hFF));

    for (int i = 0; i < 4; i++)
      drive("gate_off", 0, 0, 2'd2, 0, 3'd0,
            mk(4'b0000, 2'd3, 0, 0, 8'hFF));
    drive("gate_on", 1, 0, 2'd2, 0, 3'd0,
          mk(4'b0100, 2'd2, 0, 0, 8'hFF));

    async_rst("rst_pre_scan");

    // Step every 3rd edge from idx 0; wrap on the 12th edge.
    for (int k = 1; k <= 19; k++)
      drive("scan", 1, 1, 2'd0, 0, 3'd0,
            mk(4'b0001 << ((k / 3) % 4), 2'((k / 3) % 4),
               (k % 3) == 0, k == 12, 8'hFF));

    for (int i = 0; i < 5; i++)
      drive("freeze", 0, 1, 2'd0, 0, 3'd0,
            mk(4'b0000, 2'd2, 0, 0, 8'hFF));
    drive("resume1", 1, 1, 2'd0, 0, 3'd0,
          mk(4'b0100, 2'd2, 0, 0, 8'hFF));
    drive("resume2", 1, 1, 2'd0, 0, 3'd0,
          mk(4'b1000, 2'd3, 1, 0, 8'hFF));
    drive("pre_rst", 1, 1, 2'd0, 0, 3'd0,
          mk(4'b1000, 2'd3, 0, 0, 8'hFF));

    async_rst("rst_mid_scan");
    drive("restart1", 1, 1, 2'd0, 0, 3'd0,
          mk(4'b0001, 2'd0, 0, 0, 8'hFF));
    drive("restart2", 1, 1, 2'd0, 0, 3'd0,
          mk(4'b0001, 2'd0, 0, 0, 8'hFF));
    drive("restart3", 1, 1, 2'd0, 0, 3'd0,
          mk(4'b0010, 2'd1, 1, 0, 8'hFF));

    drive("d2s_load", 1, 0, 2'd2, 0, 3'd0,
          mk(4'b0100, 2'd2, 0, 0, 8'hFF));
    drive("d2s_1", 1, 1, 2'd0, 0, 3'd0,
          mk(4'b0100, 2'd2, 0, 0, 8'hFF));
    drive("d2s_2", 1, 1, 2'd0, 0, 3'd0,
          mk(4'b0100, 2'd2, 0, 0, 8'hFF));
    drive("d2s_3", 1, 1, 2'd0, 0, 3'd0,
          mk(4'b1000, 2'd3, 1, 0, 8'hFF));
    drive("s2d_pend", 1, 1, 2'd0, 0, 3'd0,
          mk(4'b1000, 2'd3, 0, 0, 8'hFF));
    drive("s2d_load", 1, 0, 2'd1, 0, 3'd0,
          mk(4'b0010, 2'd1, 0, 0, 8'hFF));

    drive("al_direct", 0, 0, 2'd1, 1, 3'd5,
          mk(4'b0000, 2'd1, 0, 0, 8'b1101_1111));
    drive("al_off", 0, 0, 2'd1, 0, 3'd5,
          mk(4'b0000, 2'd1, 0, 0, 8'hFF));
    drive("al_on", 0, 0, 2'd1, 1, 3'd5,
          mk(4'b0000, 2'd1, 0, 0, 8'b1101_1111));
    async_rst("al_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
